// File: rtl/perf_monitor.sv
// Run-statistics unit: counts cycles, retires, stalls and flushes until stop plus a drain
// window, then computes CPI = cycles / retires in Q(CNT_W-FRAC_W).FRAC_W with a restoring divider.
module perf_monitor #(
    parameter int CNT_W        = 32,
    parameter int FRAC_W       = 16,
    parameter int DRAIN_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic             stop,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] inst_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] cpi,
    output logic             div0,
    output logic             busy,
    output logic             done
);

    localparam int DW    = CNT_W + FRAC_W;
    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int IT_W  = $clog2(DW + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {RUN, DRAIN, DIV, DONE} state_e;

    state_e             state_q, state_d;
    logic [DRN_W-1:0]   drain_q, drain_d;
    logic [IT_W-1:0]    iter_q, iter_d;
    logic [DW-1:0]      dq_q, dq_d;        // dividend bits shift out of the top, quotient bits in at the bottom
    logic [CNT_W-1:0]   divisor_q, divisor_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   inst_q, inst_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]   flush_q, flush_d;
    logic [CNT_W-1:0]   cpi_q, cpi_d;
    logic               div0_q, div0_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [CNT_W:0]     rem_shift;
    logic               rem_ge;
    logic [DW-1:0]      quo_fin;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && v != CNT_MAX) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        // NOTE: every _d gets its current value first so no path can infer a latch.
        state_d   = state_q;
        drain_d   = drain_q;
        iter_d    = iter_q;
        dq_d      = dq_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        cycle_d   = cycle_q;
        inst_d    = inst_q;
        stall_d   = stall_q;
        flush_d   = flush_q;
        cpi_d     = cpi_q;
        div0_d    = div0_q;

        rem_shift = {rem_q, dq_q[DW-1]};
        rem_ge    = rem_shift >= {1'b0, divisor_q};
        quo_fin   = {dq_q[DW-2:0], rem_ge};

        if (state_q == RUN || state_q == DRAIN) begin
            cycle_d = sat_inc(cycle_q, 1'b1);
            inst_d  = sat_inc(inst_q, inst_valid);
            stall_d = sat_inc(stall_q, stall);
            flush_d = sat_inc(flush_q, flush);
        end

        case (state_q)
            RUN: begin
                if (stop) begin
                    state_d = DRAIN;
                    drain_d = DRN_W'(DRAIN_CYCLES);
                end
            end
            DRAIN: begin
                drain_d = drain_q - DRN_W'(1);
                if (drain_q == DRN_W'(1)) begin
                    state_d = DIV;
                    iter_d  = '0;
                end
            end
            DIV: begin
                if (iter_q == '0) begin
                    dq_d      = {cycle_q, {FRAC_W{1'b0}}};
                    divisor_d = inst_q;
                    rem_d     = '0;
                    iter_d    = IT_W'(DW);
                    if (inst_q == '0) begin
                        cpi_d   = '1;
                        div0_d  = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    // Remainder stays below the divisor, so the low CNT_W bits of the difference are exact.
                    rem_d  = rem_ge ? rem_shift[CNT_W-1:0] - divisor_q : rem_shift[CNT_W-1:0];
                    dq_d   = quo_fin;
                    iter_d = iter_q - IT_W'(1);
                    if (iter_q == IT_W'(1)) begin
                        cpi_d   = (|quo_fin[DW-1:CNT_W]) ? '1 : quo_fin[CNT_W-1:0];
                        div0_d  = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
            end
        endcase

        busy_d = (state_d == DRAIN) || (state_d == DIV);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            drain_q   <= '0;
            iter_q    <= '0;
            dq_q      <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            cycle_q   <= '0;
            inst_q    <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
            cpi_q     <= '0;
            div0_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            drain_q   <= drain_d;
            iter_q    <= iter_d;
            dq_q      <= dq_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            cycle_q   <= cycle_d;
            inst_q    <= inst_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            cpi_q     <= cpi_d;
            div0_q    <= div0_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign cycle_count = cycle_q;
    assign inst_count  = inst_q;
    assign stall_count = stall_q;
    assign flush_count = flush_q;
    assign cpi         = cpi_q;
    assign div0        = div0_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Bench for perf_monitor: directed scenarios on three parameterisations plus randomized
// runs compared against an arithmetic reference model of the expected statistics.
module tb_perf_monitor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default instance: CNT_W=32, FRAC_W=16, DRAIN_CYCLES=10
    logic        a_iv, a_st, a_fl, a_sp;
    logic [31:0] a_cyc, a_inst, a_stl, a_fls, a_cpi;
    logic        a_div0, a_busy, a_done;

    // Short-drain instance: DRAIN_CYCLES=4
    logic        b_iv, b_st, b_fl, b_sp;
    logic [31:0] b_cyc, b_inst, b_stl, b_fls, b_cpi;
    logic        b_div0, b_busy, b_done;

    // Narrow instance for saturation: CNT_W=8, FRAC_W=4, DRAIN_CYCLES=2
    logic        c_iv, c_st, c_fl, c_sp;
    logic [7:0]  c_cyc, c_inst, c_stl, c_fls, c_cpi;
    logic        c_div0, c_busy, c_done;

    perf_monitor dut_a (
        .clk(clk), .rst(rst), .inst_valid(a_iv), .stall(a_st), .flush(a_fl), .stop(a_sp),
        .cycle_count(a_cyc), .inst_count(a_inst), .stall_count(a_stl), .flush_count(a_fls),
        .cpi(a_cpi), .div0(a_div0), .busy(a_busy), .done(a_done)
    );

    perf_monitor #(.DRAIN_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .inst_valid(b_iv), .stall(b_st), .flush(b_fl), .stop(b_sp),
        .cycle_count(b_cyc), .inst_count(b_inst), .stall_count(b_stl), .flush_count(b_fls),
        .cpi(b_cpi), .div0(b_div0), .busy(b_busy), .done(b_done)
    );

    perf_monitor #(.CNT_W(8), .FRAC_W(4), .DRAIN_CYCLES(2)) dut_c (
        .clk(clk), .rst(rst), .inst_valid(c_iv), .stall(c_st), .flush(c_fl), .stop(c_sp),
        .cycle_count(c_cyc), .inst_count(c_inst), .stall_count(c_stl), .flush_count(c_fls),
        .cpi(c_cpi), .div0(c_div0), .busy(c_busy), .done(c_done)
    );

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    typedef struct {
        logic iv, st, fl, sp;
        int   cyc, inst, stl, fls;
        logic busy, done;
    } vec_t;

    vec_t vt[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic idle_inputs();
        {a_iv, a_st, a_fl, a_sp} = '0;
        {b_iv, b_st, b_fl, b_sp} = '0;
        {c_iv, c_st, c_fl, c_sp} = '0;
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases at a falling edge.
    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        #2;
        check("rst_a_cnt", {a_cyc, a_inst} | {a_stl, a_fls}, 64'd0);
        check("rst_a_res", {a_cpi, 29'd0, a_div0, a_busy, a_done}, 64'd0);
        check("rst_bc", {b_cyc | b_inst | b_cpi, c_cyc | c_inst | c_cpi, c_busy, c_done, b_busy, b_done},
              64'd0);
        @(negedge clk);
        rst = 1'b1;
        edge_n = 0;
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0: return a_done;
            1: return b_done;
            default: return c_done;
        endcase
    endfunction

    // Returns the edge after which done was first seen high, or -1 if the budget expired.
    task automatic wait_done(input int sel, input int budget, output int de);
        de = -1;
        for (int i = 0; i < budget; i++) begin
            if (done_of(sel)) begin
                de = edge_n;
                break;
            end
            tick();
        end
        if (de < 0 && done_of(sel)) de = edge_n;
    endtask

    task automatic run_s1(input string tag);
        int de;
        for (int e = 1; e <= 20; e++) begin
            a_iv = 1'b1;
            a_sp = (e == 20);
            tick();
        end
        check({tag, "_busy_after_e0"}, a_busy, 1);
        a_iv = 1'b0;
        a_sp = 1'b0;
        wait_done(0, 100, de);
        check({tag, "_done_edge"}, de, 79);
        check({tag, "_cycles"}, a_cyc, 30);
        check({tag, "_inst"}, a_inst, 20);
        check({tag, "_cpi"}, a_cpi, 32'h0001_8000);
        check({tag, "_div0_busy"}, {a_div0, a_busy}, 0);
    endtask

    initial begin
        int de;
        rst = 1'b1;
        idle_inputs();

        // iv st fl sp | cyc inst stall flush | busy done   (DRAIN_CYCLES=4, stop on edge 6)
        vt[0]  = '{1, 1, 0, 0,  1, 1, 1, 0, 0, 0};
        vt[1]  = '{0, 1, 0, 0,  2, 1, 2, 0, 0, 0};
        vt[2]  = '{1, 0, 1, 0,  3, 2, 2, 1, 0, 0};
        vt[3]  = '{0, 1, 0, 0,  4, 2, 3, 1, 0, 0};
        vt[4]  = '{0, 0, 1, 0,  5, 2, 3, 2, 0, 0};
        vt[5]  = '{0, 1, 0, 1,  6, 2, 4, 2, 1, 0};
        vt[6]  = '{1, 0, 0, 0,  7, 3, 4, 2, 1, 0};
        vt[7]  = '{0, 1, 0, 1,  8, 3, 5, 2, 1, 0};
        vt[8]  = '{0, 0, 0, 0,  9, 3, 5, 2, 1, 0};
        vt[9]  = '{0, 0, 0, 0, 10, 3, 5, 2, 1, 0};
        vt[10] = '{1, 1, 1, 1, 10, 3, 5, 2, 1, 0};

        #12;
        do_reset();

        // Scenario 1: default instance, 20 retires, stop on edge 20
        run_s1("s1");

        // Scenarios 2 and 5: short-drain instance from the vector table
        do_reset();
        for (int i = 0; i < 11; i++) begin
            b_iv = vt[i].iv; b_st = vt[i].st; b_fl = vt[i].fl; b_sp = vt[i].sp;
            tick();
            check($sformatf("vec%0d_cnt", i + 1),
                  {b_cyc[15:0], b_inst[15:0], b_stl[15:0], b_fls[15:0]},
                  {16'(vt[i].cyc), 16'(vt[i].inst), 16'(vt[i].stl), 16'(vt[i].fls)});
            check($sformatf("vec%0d_flags", i + 1), {b_busy, b_done}, {vt[i].busy, vt[i].done});
        end
        {b_iv, b_st, b_fl, b_sp} = '0;
        wait_done(1, 100, de);
        check("s2_done_edge", de, 59);
        check("s2_cpi", b_cpi, 32'h0003_5555);
        check("s2_div0_cnt", {b_div0, b_cyc[15:0]}, {1'b0, 16'd10});

        // Scenario 3: stop on edge 1, no retires
        do_reset();
        a_sp = 1'b1;
        tick();
        a_sp = 1'b0;
        wait_done(0, 100, de);
        check("s3_done_edge", de, 12);
        check("s3_cpi", a_cpi, 32'hFFFF_FFFF);
        check("s3_div0_inst_cyc", {a_div0, a_inst, a_cyc}, {1'b1, 32'd0, 32'd11});

        // Scenario 4: inst_valid and stop held high throughout
        do_reset();
        a_iv = 1'b1;
        a_sp = 1'b1;
        wait_done(0, 100, de);
        check("s4_done_edge", de, 60);
        repeat (20) tick();
        check("s4_frozen_cnt", {a_cyc, a_inst}, {32'd11, 32'd11});
        check("s4_cpi", a_cpi, 32'h0001_0000);
        check("s4_flags", {a_div0, a_busy, a_done}, 3'b001);
        a_iv = 1'b0;
        a_sp = 1'b0;

        // Scenario 6: reset in the middle of the divide, then scenario 1 again
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            a_iv = 1'b1;
            a_sp = (e == 20);
            tick();
        end
        a_iv = 1'b0;
        a_sp = 1'b0;
        repeat (20) tick();
        check("s6_in_div", {a_busy, a_done}, 2'b10);
        do_reset();
        run_s1("s6");

        // Saturation on the narrow instance: counters clamp at 255, quotient overflow clamps cpi
        for (int t = 0; t < 2; t++) begin
            do_reset();
            for (int e = 1; e <= 300; e++) begin
                c_iv = (t == 1) || (e == 1);
                c_st = 1'b1;
                c_sp = (e == 300);
                tick();
            end
            {c_iv, c_st, c_sp} = '0;
            wait_done(2, 60, de);
            check($sformatf("sat%0d_done_edge", t), de, 315);
            check($sformatf("sat%0d_cnt", t), {c_cyc, c_inst, c_stl, c_fls},
                  {8'd255, (t == 1) ? 8'd255 : 8'd1, 8'd255, 8'd0});
            check($sformatf("sat%0d_cpi", t), {c_div0, c_cpi}, {1'b0, (t == 1) ? 8'h10 : 8'hFF});
        end

        // Randomized runs on the default instance against an arithmetic model
        for (int trial = 0; trial < 8; trial++) begin
            int s, prob, last, exp_de;
            longint m_inst, m_stl, m_fls, m_cyc;
            logic [63:0] exp_cpi;
            do_reset();
            s    = $urandom_range(1, 40);
            prob = (trial == 2) ? 0 : $urandom_range(10, 90);
            last = s + 10;
            m_inst = 0; m_stl = 0; m_fls = 0;
            de = -1;
            for (int e = 1; e <= last + 70; e++) begin
                a_iv = ($urandom_range(0, 99) < prob);
                a_st = $urandom_range(0, 1) == 1;
                a_fl = $urandom_range(0, 1) == 1;
                a_sp = (e == s) ? 1'b1 : (e < s) ? 1'b0 : ($urandom_range(0, 1) == 1);
                if (e <= last) begin
                    m_inst += a_iv;
                    m_stl  += a_st;
                    m_fls  += a_fl;
                end
                tick();
                if (a_done && de < 0) de = edge_n;
            end
            idle_inputs();
            m_cyc   = last;
            exp_de  = last + 1 + ((m_inst == 0) ? 0 : 48);
            if (m_inst == 0) exp_cpi = 64'hFFFF_FFFF;
            else begin
                exp_cpi = 64'((m_cyc << 16) / m_inst);
                if (exp_cpi > 64'hFFFF_FFFF) exp_cpi = 64'hFFFF_FFFF;
            end
            check($sformatf("rnd%0d_done_edge", trial), de, exp_de);
            check($sformatf("rnd%0d_cyc_inst", trial), {a_cyc, a_inst}, {32'(m_cyc), 32'(m_inst)});
            check($sformatf("rnd%0d_stl_fls", trial), {a_stl, a_fls}, {32'(m_stl), 32'(m_fls)});
            check($sformatf("rnd%0d_cpi", trial), a_cpi, exp_cpi);
            check($sformatf("rnd%0d_div0", trial), {a_div0, a_busy, a_done}, {m_inst == 0, 1'b0, 1'b1});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
